account_tx: RTL

ACCOUNT_TX -- requirements
Module: account_tx

---
 rtl/account_tx_pkg.sv | 14 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/account_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/account_tx_pkg.sv
// Shared project package: default field/buffer sizes and the transmit FSM
// state encoding, used by account_tx and the CDC block.
package account_tx_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; pointers carry an
// extra MSB so full and empty are distinguishable when the indices match.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int ASIZE = 3
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ASIZE;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full buffer is dropped even if a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ASIZE] != rptr[ASIZE]) &&
                   (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign rdata = mem[rptr[ASIZE-1:0]];

    always_ff @(posedge clk1) begin
        if (push_ok) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/account_tx.sv
// Buffers host records and streams a requested number of them to a sink that
// signals readiness one cycle late; counts cycles lost to an empty buffer.
module account_tx
    import account_tx_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [DSIZE-1:0] load_account,
    input  logic [DSIZE-1:0] load_A,
    input  logic [DSIZE-1:0] load_T,
    output logic             load_ready,
    input  logic             start,
    input  logic [DSIZE-1:0] burst_len,
    input  logic             ready,
    output logic             in_valid,
    output logic [DSIZE-1:0] in_account,
    output logic [DSIZE-1:0] in_A,
    output logic [DSIZE-1:0] in_T,
    output logic             busy,
    output logic             done,
    output logic [DSIZE-1:0] stall_cnt
);

    state_t             state;
    logic [DSIZE-1:0]   remaining;
    logic [3*DSIZE-1:0] fifo_rdata;
    logic               full;
    logic               empty;
    logic               pop;

    sync_fifo #(
        .WIDTH (3 * DSIZE),
        .ASIZE (ASIZE)
    ) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (load_valid),
        .pop   (pop),
        .wdata ({load_account, load_A, load_T}),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    assign load_ready = !full;
    assign pop = (state == ST_SEND) && ready && !empty && (remaining != '0);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            in_valid   <= 1'b0;
            in_account <= '0;
            in_A       <= '0;
            in_T       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            in_valid <= pop;
            done     <= 1'b0;
            if (pop) begin
                {in_account, in_A, in_T} <= fifo_rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stall_cnt <= '0;
                        busy      <= 1'b1;
                        if (burst_len != '0) begin
                            remaining <= burst_len;
                            state     <= ST_SEND;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (pop) begin
                        remaining <= remaining - DSIZE'(1);
                        if (remaining == DSIZE'(1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else if (ready && empty && stall_cnt != {DSIZE{1'b1}}) begin
                        stall_cnt <= stall_cnt + DSIZE'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
